// File: rtl/bus_hub_n.sv
// One-host to N-device memory-mapped bus hub with latched requests, priority decode and a registered response.
// Optional access watchdog is enabled by defining BUS_HUB_TIMEOUT_EN.
module bus_hub_n #(
    parameter int N_DEVICES      = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               host_address,
    input  logic [31:0]               host_data_write,
    input  logic [3:0]                host_write_mask,
    input  logic                      host_ren,
    input  logic                      host_wen,
    output logic [31:0]               host_data_read,
    output logic                      host_ready,
    output logic                      bus_error,
    output logic [32*N_DEVICES-1:0]   device_address,
    output logic [32*N_DEVICES-1:0]   device_data_write,
    output logic [4*N_DEVICES-1:0]    device_write_mask,
    output logic [N_DEVICES-1:0]      device_ren,
    output logic [N_DEVICES-1:0]      device_wen,
    input  logic [N_DEVICES-1:0]      device_ready,
    input  logic [32*N_DEVICES-1:0]   device_data_read,
    input  logic [N_DEVICES-1:0]      device_active
);

    localparam int SEL_W = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         mask_q, mask_d;
    logic               write_q, write_d;
    logic               first_q, first_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_sel;
    logic [SEL_W-1:0]   cur_sel;
    logic               strobe_on;
    logic               cur_ready;
    logic [31:0]        cur_rdata;
    logic               timeout;
    logic               start_req;

    if (N_DEVICES < 1 || TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_param_check
        $error("bus_hub_n: N_DEVICES and TIMEOUT_CYCLES must both be at least 1");
    end

    assign start_req = (state_q == IDLE) && (host_ren || host_wen);

    // Lowest-index claiming device wins; scanning downward leaves the smallest index last.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = N_DEVICES - 1; i >= 0; i--) begin
            if (device_active[i]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    // The first ACCESS cycle strobes straight from the live decode, later cycles from the registered choice.
    always_comb begin
        cur_sel   = first_q ? dec_sel : sel_q;
        strobe_on = (state_q == ACCESS) && (first_q ? dec_hit : 1'b1);
        cur_ready = device_ready[cur_sel];
        cur_rdata = device_data_read[32*int'(cur_sel) +: 32];
    end

`ifdef BUS_HUB_TIMEOUT_EN
    logic [CNT_W-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d  = wdog_q;
        timeout = strobe_on && !cur_ready && (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (start_req) begin
            wdog_d = '0;
        end else if (strobe_on && !timeout) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        write_d = write_q;
        first_d = 1'b0;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    addr_d  = host_address;
                    wdata_d = host_data_write;
                    mask_d  = host_write_mask;
                    write_d = host_wen;
                    first_d = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (first_q) begin
                    sel_d = dec_sel;
                end
                if (first_q && !dec_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cur_ready) begin
                    rdata_d = write_q ? 32'h0 : cur_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            write_q <= 1'b0;
            first_q <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            write_q <= write_d;
            first_q <= first_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        host_ready     = (state_q == RESP);
        host_data_read = host_ready ? rdata_q : 32'h0;
        bus_error      = host_ready && err_q;
    end

    always_comb begin
        device_address    = '0;
        device_data_write = '0;
        device_write_mask = '0;
        device_ren        = '0;
        device_wen        = '0;
        for (int i = 0; i < N_DEVICES; i++) begin
            device_address[32*i +: 32]   = addr_q;
            device_data_write[32*i +: 32] = wdata_q;
            device_write_mask[4*i +: 4]  = mask_q;
            device_ren[i] = strobe_on && !write_q && (cur_sel == SEL_W'(i));
            device_wen[i] = strobe_on && write_q && (cur_sel == SEL_W'(i));
        end
    end

endmodule
